mem_req_scheduler: RTL and testbench

Sits between the fetch stage, the load/store queue and the single memory port. Each cycle it picks one requester, IF or LSQ, and drives the memory command. It records which requester owns each outstanding memory transaction tag. When data returns out of order on a tag, it routes the data to the owner.

---
 rtl/mem_req_scheduler_pkg.sv | 31 +++
 rtl/mem_req_scheduler_tag_table.sv | 68 ++++++
 rtl/mem_req_scheduler.sv | 147 ++++++++++++++
 tb/tb_mem_req_scheduler.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_req_scheduler_pkg.sv
// Shared definitions for the memory request scheduler.
// Contents:
//   BUS_NONE / BUS_LOAD / BUS_STORE   memory bus command encodings
//   src_e                             owner of a tag table entry (IF or LSQ)
//   tag_entry_t                       one tag table entry {valid, src, lsq_tag}
//   MEM_TAG_W_DEF                     default memory tag width
//   LSQ_TAG_MAX_W                     storage width of the lsq_tag field
package mem_req_scheduler_pkg;

  localparam logic [1:0] BUS_NONE  = 2'h0;
  localparam logic [1:0] BUS_LOAD  = 2'h1;
  localparam logic [1:0] BUS_STORE = 2'h2;

  localparam int MEM_TAG_W_DEF = 4;

  // The entry struct is shared, so it carries a fixed-width LSQ tag field.
  // Users with a narrower LSQ tag zero-extend on write and slice on read.
  localparam int LSQ_TAG_MAX_W = 8;

  typedef enum logic {
    SRC_IF  = 1'b0,
    SRC_LSQ = 1'b1
  } src_e;

  typedef struct packed {
    logic                     valid;
    src_e                     src;
    logic [LSQ_TAG_MAX_W-1:0] lsq_tag;
  } tag_entry_t;

endpackage

// File: rtl/mem_req_scheduler_tag_table.sv
// Tag ownership table for outstanding memory loads.
// Ports:
//   clock, reset       system clock, synchronous active-high reset
//   alloc_en/tag/src/lsq_tag   write entry[alloc_tag] with a new owner
//   lookup_tag         returning memory tag (0 = nothing returning)
//   hit, hit_entry     lookup found a valid entry; that entry is freed
//   count              registered number of valid entries
module mem_req_scheduler_tag_table
  import mem_req_scheduler_pkg::*;
#(
  parameter int MEM_TAG_W = MEM_TAG_W_DEF,
  parameter int LSQ_TAG_W = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 alloc_en,
  input  logic [MEM_TAG_W-1:0] alloc_tag,
  input  src_e                 alloc_src,
  input  logic [LSQ_TAG_W-1:0] alloc_lsq_tag,
  input  logic [MEM_TAG_W-1:0] lookup_tag,
  output logic                 hit,
  output tag_entry_t           hit_entry,
  output logic [MEM_TAG_W-1:0] count
);

  localparam int DEPTH = 1 << MEM_TAG_W;

  tag_entry_t           tbl      [DEPTH];
  tag_entry_t           next_tbl [DEPTH];
  logic [MEM_TAG_W-1:0] next_count;

  // Tag 0 means "no tag", so entry 0 never hits and is never written.
  always_comb begin
    hit       = (lookup_tag != '0) && tbl[lookup_tag].valid;
    hit_entry = tbl[lookup_tag];
    next_tbl  = tbl;
    // Free first, then allocate: a same-cycle free and re-allocate of one
    // tag leaves the entry valid with the new owner.
    if (hit) begin
      next_tbl[lookup_tag].valid = 1'b0;
    end
    if (alloc_en && (alloc_tag != '0)) begin
      next_tbl[alloc_tag].valid   = 1'b1;
      next_tbl[alloc_tag].src     = alloc_src;
      next_tbl[alloc_tag].lsq_tag = LSQ_TAG_MAX_W'(alloc_lsq_tag);
    end
    // Counting the post-update table makes alloc+free in one cycle net zero.
    next_count = '0;
    for (int i = 1; i < DEPTH; i++) begin
      next_count = next_count + {{(MEM_TAG_W-1){1'b0}}, next_tbl[i].valid};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl[i] <= '0;
      end
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl[i] <= next_tbl[i];
      end
      count <= next_count;
    end
  end

endmodule

// File: rtl/mem_req_scheduler.sv
// Memory request scheduler: arbitrates the single memory port between the
// fetch stage (IF) and the load/store queue (LSQ), tracks which requester
// owns each outstanding load tag and routes out-of-order returns.
// Ports:
//   clock, reset                         clock, synchronous active-high reset
//   if_req_valid/addr, if_grant          IF load request and acceptance
//   if_resp_valid/data                   IF load data (1 cycle after return)
//   lsq_req_valid/read/addr/data/tag     LSQ load/store request
//   lsq_grant                            LSQ request acceptance
//   lsq_resp_valid/data/tag              LSQ load data and its LSQ tag
//   proc2mem_command/addr/data           memory command bus
//   mem2proc_response/data/tag           memory accept tag and return data
//   outstanding                          number of tracked loads
//   spurious_err                         sticky: return with no owner
//
// Handshake: a requester asserts its valid and holds the request until its
// grant is seen high in the same cycle. A grant is given only to the
// arbitration winner and only when memory accepts (mem2proc_response != 0).
module mem_req_scheduler
  import mem_req_scheduler_pkg::*;
#(
  parameter int MEM_TAG_W    = MEM_TAG_W_DEF,
  parameter int LSQ_TAG_W    = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 if_req_valid,
  input  logic [63:0]          if_req_addr,
  output logic                 if_grant,
  output logic                 if_resp_valid,
  output logic [63:0]          if_resp_data,
  input  logic                 lsq_req_valid,
  input  logic                 lsq_req_read,
  input  logic [63:0]          lsq_req_addr,
  input  logic [63:0]          lsq_req_data,
  input  logic [LSQ_TAG_W-1:0] lsq_req_tag,
  output logic                 lsq_grant,
  output logic                 lsq_resp_valid,
  output logic [63:0]          lsq_resp_data,
  output logic [LSQ_TAG_W-1:0] lsq_resp_tag,
  output logic [1:0]           proc2mem_command,
  output logic [63:0]          proc2mem_addr,
  output logic [63:0]          proc2mem_data,
  input  logic [MEM_TAG_W-1:0] mem2proc_response,
  input  logic [63:0]          mem2proc_data,
  input  logic [MEM_TAG_W-1:0] mem2proc_tag,
  output logic [MEM_TAG_W-1:0] outstanding,
  output logic                 spurious_err
);

  localparam int                CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             mem_ready;
  logic             if_wins;
  logic             lsq_wins;
  logic             alloc_en;
  src_e             alloc_src;
  logic             hit;
  tag_entry_t       hit_entry;
  logic             hit_if;
  logic             hit_lsq;

  always_comb begin
    mem_ready = (mem2proc_response != '0);
    // LSQ has priority unless IF has been denied STARVE_LIMIT cycles in a row.
    if_wins   = if_req_valid && ((starve_cnt == LIMIT) || !lsq_req_valid);
    lsq_wins  = lsq_req_valid && !if_wins;

    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    if (if_wins) begin
      proc2mem_command = BUS_LOAD;
      proc2mem_addr    = if_req_addr;
    end else if (lsq_wins) begin
      proc2mem_command = lsq_req_read ? BUS_LOAD : BUS_STORE;
      proc2mem_addr    = lsq_req_addr;
      proc2mem_data    = lsq_req_read ? 64'h0 : lsq_req_data;
    end
    // Never issue to memory while in reset; address/data may still follow.
    if (reset) begin
      proc2mem_command = BUS_NONE;
    end

    if_grant  = if_wins  && mem_ready && !reset;
    lsq_grant = lsq_wins && mem_ready && !reset;

    // Stores complete without a return, so only loads take a tag entry.
    alloc_en  = if_grant || (lsq_grant && lsq_req_read);
    alloc_src = if_grant ? SRC_IF : SRC_LSQ;

    hit_if  = hit && (hit_entry.src == SRC_IF);
    hit_lsq = hit && (hit_entry.src == SRC_LSQ);
  end

  mem_req_scheduler_tag_table #(
    .MEM_TAG_W (MEM_TAG_W),
    .LSQ_TAG_W (LSQ_TAG_W)
  ) u_tag_table (
    .clock         (clock),
    .reset         (reset),
    .alloc_en      (alloc_en),
    .alloc_tag     (mem2proc_response),
    .alloc_src     (alloc_src),
    .alloc_lsq_tag (lsq_req_tag),
    .lookup_tag    (mem2proc_tag),
    .hit           (hit),
    .hit_entry     (hit_entry),
    .count         (outstanding)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (if_req_valid && !if_grant) begin
      if (starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end else begin
      starve_cnt <= '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      if_resp_valid  <= 1'b0;
      if_resp_data   <= '0;
      lsq_resp_valid <= 1'b0;
      lsq_resp_data  <= '0;
      lsq_resp_tag   <= '0;
      spurious_err   <= 1'b0;
    end else begin
      if_resp_valid  <= hit_if;
      if_resp_data   <= hit_if ? mem2proc_data : 64'h0;
      lsq_resp_valid <= hit_lsq;
      lsq_resp_data  <= hit_lsq ? mem2proc_data : 64'h0;
      lsq_resp_tag   <= hit_lsq ? hit_entry.lsq_tag[LSQ_TAG_W-1:0] : '0;
      if ((mem2proc_tag != '0) && !hit) begin
        spurious_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_req_scheduler.sv
// Directed testbench for mem_req_scheduler. Inputs change just after the
// falling edge; combinational outputs are checked 1 time unit later and
// registered outputs at the following falling edge.
module tb_mem_req_scheduler;

  localparam int MEM_TAG_W = 4;
  localparam int LSQ_TAG_W = 5;

  localparam logic [1:0] C_NONE  = 2'h0;
  localparam logic [1:0] C_LOAD  = 2'h1;
  localparam logic [1:0] C_STORE = 2'h2;

  logic                 clock;
  logic                 reset;
  logic                 if_req_valid;
  logic [63:0]          if_req_addr;
  logic                 if_grant;
  logic                 if_resp_valid;
  logic [63:0]          if_resp_data;
  logic                 lsq_req_valid;
  logic                 lsq_req_read;
  logic [63:0]          lsq_req_addr;
  logic [63:0]          lsq_req_data;
  logic [LSQ_TAG_W-1:0] lsq_req_tag;
  logic                 lsq_grant;
  logic                 lsq_resp_valid;
  logic [63:0]          lsq_resp_data;
  logic [LSQ_TAG_W-1:0] lsq_resp_tag;
  logic [1:0]           proc2mem_command;
  logic [63:0]          proc2mem_addr;
  logic [63:0]          proc2mem_data;
  logic [MEM_TAG_W-1:0] mem2proc_response;
  logic [63:0]          mem2proc_data;
  logic [MEM_TAG_W-1:0] mem2proc_tag;
  logic [MEM_TAG_W-1:0] outstanding;
  logic                 spurious_err;

  int checks = 0;
  int errors = 0;

  mem_req_scheduler #(
    .MEM_TAG_W    (MEM_TAG_W),
    .LSQ_TAG_W    (LSQ_TAG_W),
    .STARVE_LIMIT (4)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .if_req_valid      (if_req_valid),
    .if_req_addr       (if_req_addr),
    .if_grant          (if_grant),
    .if_resp_valid     (if_resp_valid),
    .if_resp_data      (if_resp_data),
    .lsq_req_valid     (lsq_req_valid),
    .lsq_req_read      (lsq_req_read),
    .lsq_req_addr      (lsq_req_addr),
    .lsq_req_data      (lsq_req_data),
    .lsq_req_tag       (lsq_req_tag),
    .lsq_grant         (lsq_grant),
    .lsq_resp_valid    (lsq_resp_valid),
    .lsq_resp_data     (lsq_resp_data),
    .lsq_resp_tag      (lsq_resp_tag),
    .proc2mem_command  (proc2mem_command),
    .proc2mem_addr     (proc2mem_addr),
    .proc2mem_data     (proc2mem_data),
    .mem2proc_response (mem2proc_response),
    .mem2proc_data     (mem2proc_data),
    .mem2proc_tag      (mem2proc_tag),
    .outstanding       (outstanding),
    .spurious_err      (spurious_err)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #50000;
    $display("FAIL timeout: observed no end of test, expected finish before 50000");
    $fatal(1, "timeout");
  end

  // Comparison point
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic idle_inputs();
    if_req_valid      = 1'b0;
    if_req_addr       = 64'h0;
    lsq_req_valid     = 1'b0;
    lsq_req_read      = 1'b0;
    lsq_req_addr      = 64'h0;
    lsq_req_data      = 64'h0;
    lsq_req_tag       = '0;
    mem2proc_response = '0;
    mem2proc_data     = 64'h0;
    mem2proc_tag      = '0;
  endtask

  task automatic drive_if(input logic [63:0] addr);
    if_req_valid = 1'b1;
    if_req_addr  = addr;
  endtask

  task automatic drive_lsq(input logic rd, input logic [63:0] addr,
                           input logic [63:0] data, input logic [LSQ_TAG_W-1:0] tag);
    lsq_req_valid = 1'b1;
    lsq_req_read  = rd;
    lsq_req_addr  = addr;
    lsq_req_data  = data;
    lsq_req_tag   = tag;
  endtask

  task automatic mem_return(input logic [MEM_TAG_W-1:0] tag, input logic [63:0] data);
    mem2proc_tag  = tag;
    mem2proc_data = data;
  endtask

  int          drain_tags [6] = '{6, 5, 4, 3, 2, 1};
  logic [63:0] exp_addr;

  initial begin
    idle_inputs();
    reset = 1'b1;

    // Reset: memory must not be driven even with a request and an accept.
    drive_if(64'h100);
    drive_lsq(1'b1, 64'h300, 64'h0, 5'd1);
    mem2proc_response = 4'd3;
    #1;
    check("rst_cmd", {62'h0, proc2mem_command}, {62'h0, C_NONE});
    check("rst_if_grant", {63'h0, if_grant}, 64'h0);
    check("rst_lsq_grant", {63'h0, lsq_grant}, 64'h0);
    @(negedge clock);
    @(negedge clock);
    check("rst_outstanding", {60'h0, outstanding}, 64'h0);
    check("rst_spurious", {63'h0, spurious_err}, 64'h0);
    check("rst_if_resp_valid", {63'h0, if_resp_valid}, 64'h0);
    check("rst_if_resp_data", if_resp_data, 64'h0);
    check("rst_lsq_resp_valid", {63'h0, lsq_resp_valid}, 64'h0);
    check("rst_lsq_resp_tag", {59'h0, lsq_resp_tag}, 64'h0);
    check("rst_lsq_resp_data", lsq_resp_data, 64'h0);
    idle_inputs();
    reset = 1'b0;
    @(negedge clock);

    // IF only load, accepted on tag 3, data returned on tag 3.
    drive_if(64'h100);
    mem2proc_response = 4'd3;
    #1;
    check("t1_if_grant", {63'h0, if_grant}, 64'h1);
    check("t1_lsq_grant", {63'h0, lsq_grant}, 64'h0);
    check("t1_cmd", {62'h0, proc2mem_command}, {62'h0, C_LOAD});
    check("t1_addr", proc2mem_addr, 64'h100);
    check("t1_data", proc2mem_data, 64'h0);
    @(negedge clock);
    check("t1_outstanding_1", {60'h0, outstanding}, 64'h1);
    idle_inputs();
    mem_return(4'd3, 64'hDEAD);
    #1;
    check("t1_idle_cmd", {62'h0, proc2mem_command}, {62'h0, C_NONE});
    check("t1_idle_addr", proc2mem_addr, 64'h0);
    @(negedge clock);
    check("t1_if_resp_valid", {63'h0, if_resp_valid}, 64'h1);
    check("t1_if_resp_data", if_resp_data, 64'hDEAD);
    check("t1_lsq_resp_valid", {63'h0, lsq_resp_valid}, 64'h0);
    check("t1_outstanding_0", {60'h0, outstanding}, 64'h0);
    idle_inputs();
    @(negedge clock);
    check("t1_if_resp_drop", {63'h0, if_resp_valid}, 64'h0);

    // IF and LSQ load every cycle: LSQ 4 times, IF 5th, then LSQ again.
    for (int k = 0; k < 6; k++) begin
      drive_if(64'h100);
      drive_lsq(1'b1, 64'h300, 64'h0, 5'd7);
      mem2proc_response = 4'(k + 1);
      #1;
      check($sformatf("t2_if_grant_%0d", k), {63'h0, if_grant}, (k == 4) ? 64'h1 : 64'h0);
      check($sformatf("t2_lsq_grant_%0d", k), {63'h0, lsq_grant}, (k == 4) ? 64'h0 : 64'h1);
      check($sformatf("t2_cmd_%0d", k), {62'h0, proc2mem_command}, {62'h0, C_LOAD});
      exp_addr = (k == 4) ? 64'h100 : 64'h300;
      check($sformatf("t2_addr_%0d", k), proc2mem_addr, exp_addr);
      @(negedge clock);
    end
    idle_inputs();
    check("t2_outstanding", {60'h0, outstanding}, 64'h6);

    // Drain in reverse order; tag 5 belongs to IF, the rest to LSQ tag 7.
    for (int i = 0; i < 6; i++) begin
      mem_return(4'(drain_tags[i]), 64'hA000 + 64'(drain_tags[i]));
      @(negedge clock);
      if (drain_tags[i] == 5) begin
        check("t2_drain_if_valid", {63'h0, if_resp_valid}, 64'h1);
        check("t2_drain_if_data", if_resp_data, 64'hA005);
        check("t2_drain_if_lsq_valid", {63'h0, lsq_resp_valid}, 64'h0);
      end else begin
        check($sformatf("t2_drain_lsq_valid_%0d", drain_tags[i]), {63'h0, lsq_resp_valid}, 64'h1);
        check($sformatf("t2_drain_lsq_tag_%0d", drain_tags[i]), {59'h0, lsq_resp_tag}, 64'h7);
        check($sformatf("t2_drain_lsq_data_%0d", drain_tags[i]), lsq_resp_data,
              64'hA000 + 64'(drain_tags[i]));
        check($sformatf("t2_drain_if_valid_%0d", drain_tags[i]), {63'h0, if_resp_valid}, 64'h0);
      end
      check($sformatf("t2_drain_outstanding_%0d", i), {60'h0, outstanding}, 64'(5 - i));
    end
    idle_inputs();
    @(negedge clock);

    // LSQ store: BUS_STORE with data, no table entry.
    drive_lsq(1'b0, 64'h200, 64'h55, 5'd9);
    mem2proc_response = 4'd8;
    #1;
    check("t3_cmd", {62'h0, proc2mem_command}, {62'h0, C_STORE});
    check("t3_addr", proc2mem_addr, 64'h200);
    check("t3_data", proc2mem_data, 64'h55);
    check("t3_lsq_grant", {63'h0, lsq_grant}, 64'h1);
    check("t3_if_grant", {63'h0, if_grant}, 64'h0);
    @(negedge clock);
    check("t3_outstanding", {60'h0, outstanding}, 64'h0);
    idle_inputs();

    // Loads on tags 1 (LSQ tag 0x11) and 2 (IF), returned 2 then 1.
    drive_lsq(1'b1, 64'h340, 64'h77, 5'h11);
    mem2proc_response = 4'd1;
    #1;
    check("t4_lsq_load_data0", proc2mem_data, 64'h0);
    @(negedge clock);
    idle_inputs();
    drive_if(64'h140);
    mem2proc_response = 4'd2;
    @(negedge clock);
    check("t4_outstanding_2", {60'h0, outstanding}, 64'h2);
    idle_inputs();
    mem_return(4'd2, 64'hB2);
    @(negedge clock);
    check("t4_ret2_if_valid", {63'h0, if_resp_valid}, 64'h1);
    check("t4_ret2_if_data", if_resp_data, 64'hB2);
    check("t4_ret2_lsq_valid", {63'h0, lsq_resp_valid}, 64'h0);
    mem_return(4'd1, 64'hB1);
    @(negedge clock);
    check("t4_ret1_lsq_valid", {63'h0, lsq_resp_valid}, 64'h1);
    check("t4_ret1_lsq_tag", {59'h0, lsq_resp_tag}, 64'h11);
    check("t4_ret1_lsq_data", lsq_resp_data, 64'hB1);
    check("t4_ret1_if_valid", {63'h0, if_resp_valid}, 64'h0);
    check("t4_outstanding_0", {60'h0, outstanding}, 64'h0);
    idle_inputs();

    // Same-cycle free and re-allocate of tag 4: old owner gets the data.
    drive_lsq(1'b1, 64'h380, 64'h0, 5'd3);
    mem2proc_response = 4'd4;
    @(negedge clock);
    check("t5_outstanding_1", {60'h0, outstanding}, 64'h1);
    idle_inputs();
    drive_if(64'h180);
    mem2proc_response = 4'd4;
    mem_return(4'd4, 64'hC4);
    #1;
    check("t5_if_grant", {63'h0, if_grant}, 64'h1);
    @(negedge clock);
    check("t5_old_lsq_valid", {63'h0, lsq_resp_valid}, 64'h1);
    check("t5_old_lsq_tag", {59'h0, lsq_resp_tag}, 64'h3);
    check("t5_old_lsq_data", lsq_resp_data, 64'hC4);
    check("t5_old_if_valid", {63'h0, if_resp_valid}, 64'h0);
    check("t5_outstanding_net0", {60'h0, outstanding}, 64'h1);
    idle_inputs();
    mem_return(4'd4, 64'hD4);
    @(negedge clock);
    check("t5_new_if_valid", {63'h0, if_resp_valid}, 64'h1);
    check("t5_new_if_data", if_resp_data, 64'hD4);
    check("t5_new_lsq_valid", {63'h0, lsq_resp_valid}, 64'h0);
    check("t5_outstanding_0", {60'h0, outstanding}, 64'h0);
    idle_inputs();

    // Memory busy for 6 cycles with both requesting: no grants, command
    // still driven, IF takes over once its counter saturates at 4.
    for (int k = 0; k < 6; k++) begin
      drive_if(64'h100);
      drive_lsq(1'b1, 64'h300, 64'h0, 5'd2);
      mem2proc_response = 4'd0;
      #1;
      check($sformatf("t6_if_grant_%0d", k), {63'h0, if_grant}, 64'h0);
      check($sformatf("t6_lsq_grant_%0d", k), {63'h0, lsq_grant}, 64'h0);
      check($sformatf("t6_cmd_%0d", k), {62'h0, proc2mem_command}, {62'h0, C_LOAD});
      exp_addr = (k < 4) ? 64'h300 : 64'h100;
      check($sformatf("t6_addr_%0d", k), proc2mem_addr, exp_addr);
      @(negedge clock);
    end
    mem2proc_response = 4'd5;
    #1;
    check("t6_if_grant_sat", {63'h0, if_grant}, 64'h1);
    check("t6_lsq_grant_sat", {63'h0, lsq_grant}, 64'h0);
    @(negedge clock);
    check("t6_outstanding", {60'h0, outstanding}, 64'h1);
    idle_inputs();

    // Return on tag 9 with no entry: no response, sticky error.
    mem_return(4'd9, 64'hE9);
    @(negedge clock);
    check("t7_sp_if_valid", {63'h0, if_resp_valid}, 64'h0);
    check("t7_sp_lsq_valid", {63'h0, lsq_resp_valid}, 64'h0);
    check("t7_sp_err", {63'h0, spurious_err}, 64'h1);
    idle_inputs();
    @(negedge clock);
    check("t7_sp_err_sticky", {63'h0, spurious_err}, 64'h1);
    check("t7_outstanding", {60'h0, outstanding}, 64'h1);

    // Reset with tag 5 in flight: table, count and error cleared.
    reset = 1'b1;
    drive_if(64'h1C0);
    mem2proc_response = 4'd6;
    #1;
    check("t7_rst_cmd", {62'h0, proc2mem_command}, {62'h0, C_NONE});
    check("t7_rst_if_grant", {63'h0, if_grant}, 64'h0);
    check("t7_rst_addr_follows", proc2mem_addr, 64'h1C0);
    @(negedge clock);
    check("t7_rst_outstanding", {60'h0, outstanding}, 64'h0);
    check("t7_rst_err", {63'h0, spurious_err}, 64'h0);
    reset = 1'b0;
    idle_inputs();
    mem_return(4'd5, 64'hF5);
    @(negedge clock);
    check("t7_post_if_valid", {63'h0, if_resp_valid}, 64'h0);
    check("t7_post_err", {63'h0, spurious_err}, 64'h1);
    check("t7_post_outstanding", {60'h0, outstanding}, 64'h0);
    idle_inputs();
    @(negedge clock);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
